stream_sink: RTL and testbench
==============================

# stream_sink

Receive-side counterpart of `stream_gen`. It accepts an AXI-Stream byte stream from any `m_axis_data_*` port of an `i2c_master` or `i2c_slave` in the multi-master bench and buffers each byte with its `tlast` flag in a FIFO. The bench drains the buffer through a pop interface. Frame boundaries are tracked, and each completed frame is reported with its length, so directed tests can compare received bytes and framing against what `stream_gen` pushed.

## Interface
- `DEPTH`, default 16: FIFO entries; any value ≥2.
- `CW`, default `$clog2(DEPTH+1)`: width of `buff_count`.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `tdata`  input  8  stream byte.
- `tvalid`  input  1  `tdata`/`tlast` valid.
- `tready`  output  1  sink accepts the beat this cycle.
- `tlast`  input  1  last byte of frame.
- `in_en`  input  1  enables acceptance; mirror of `stream_gen` `op_en`.
- `pop`  input  1  remove head entry.
- `Dout`  output  8  head-entry byte (show-ahead).
- `Dout_last`  output  1  head-entry `tlast` flag.
- `buff_count`  output  CW  entries held, 0..DEPTH.
- `empty`  output  1  `buff_count == 0`.
- `full`  output  1  `buff_count == DEPTH`.
- `frame_done`  output  1  one-cycle pulse when a `tlast` beat is accepted.
- `frame_len`  output  8  beats in the last completed frame, `tlast` beat included; saturates at 255.
- `frame_count`  output  8  completed frames; wraps 255→0.
- `in_frame`  output  1  FSM is in FRAME.

## Operation
- Storage: DEPTH × 9-bit entries `{tlast, tdata}`, with a write pointer, a read pointer and an occupancy counter. Pointers wrap from DEPTH-1 to 0.
- Handshake: `tready = in_en & ~full`. It depends only on registered state and `in_en`, with no combinational path from `tvalid`. A beat is accepted on an edge where `tvalid & tready`.
- Pop: effective when `pop & ~empty`. A pop when empty is ignored; pointers and count do not change.
- Simultaneous accept and effective pop: both occur and `buff_count` is unchanged.
  - When full, `tready` is 0, so accept never coincides with full.
  - When empty, the pop is ignored, so only the accept takes effect.
- `Dout`/`Dout_last` show the entry at the read pointer whenever `~empty`. When empty they hold their last value; the bench must not sample them then.
- Frame FSM, states IDLE and FRAME:
  - IDLE, accept with `tlast=0` → FRAME; `len_cnt <= 1`.
  - IDLE, accept with `tlast=1` → stay in IDLE; single-beat frame, `frame_done` with `frame_len=1`.
  - FRAME, accept with `tlast=0` → stay in FRAME; `len_cnt` increments, saturating at 255.
  - FRAME, accept with `tlast=1` → IDLE; `frame_len <= sat(len_cnt+1)`, `frame_done` pulses, `frame_count` increments.
  - No accept → state holds. Deasserting `in_en` mid-frame does not abort the frame.
- `in_frame = (state == FRAME)`.
- Reset (`rst=0`, asynchronous):
  - Pointers, count, `len_cnt`, `frame_len`, `frame_count`, `Dout` and `Dout_last` go to 0.
  - `empty=1`, `full=0`, `frame_done=0`, `in_frame=0`, state IDLE.
  - `tready` is forced to 0 while in reset.
  - A reset mid-frame discards the buffer and the partial frame; the next accepted beat starts a new frame.
  - Release is synchronous to `clk`; the first accept can occur on the first edge after deassertion.

## Timing
- Accept at edge N:
  - `buff_count`, `empty`, `full`, `Dout` and the FSM state update at N.
  - The byte is visible on `Dout` in cycle N+1 if the buffer was empty (1-cycle latency).
- Pop at edge N: the next entry is on `Dout` in cycle N+1.
- `frame_done` is high for exactly the cycle after the accepting edge of the `tlast` beat. `frame_len` and `frame_count` are valid from that cycle and held until the next frame completes.
- `full` asserts the cycle after the DEPTH-th entry is stored; `tready` drops in the same cycle.
- Back-to-back: with `tvalid` held high, one beat per clock up to DEPTH, with no bubbles.

## Test plan
- Stream 0x11, 0x22, 0x33 (`tlast` on 0x33) with `in_en=1`, then pop 3 times:
  - `Dout` gives 0x11, 0x22, 0x33; `Dout_last` reads 0, 0, 1.
  - `frame_done` pulses once with `frame_len=3`, `frame_count=1`, and `empty=1` at the end.
- Push 16 beats with no pop (DEPTH=16):
  - `full=1` and `buff_count=16`; `tready=0` and the 17th beat is held off.
  - After one pop, `tready=1` and the held beat is accepted.
- With `buff_count=5`, assert accept and pop on the same edge for 4 cycles:
  - `buff_count` stays 5 and the order is preserved.
  - A pop while empty leaves `buff_count=0` and the pointers unchanged.
- Single-beat frames with `tlast=1`, repeated 257 times while popping continuously:
  - `frame_len=1` each time; `frame_count` wraps to 1; the FSM never leaves IDLE.
- Pull `rst` low after 2 beats of a frame (`in_frame=1`):
  - Immediately `empty=1`, `in_frame=0`, `tready=0`.
  - After release, a 2-beat frame reports `frame_len=2`.
- Frame of 300 beats, popped as it streams:
  - `frame_len=255` (saturated).
  - Deasserting `in_en` for 10 cycles mid-frame keeps `tready=0` and `in_frame=1`.

Source files
------------

// File: rtl/stream_sink.sv
// stream_sink: receive-side AXI-Stream byte sink with a show-ahead FIFO and
// frame tracking.
//
// Each accepted beat is stored as {tlast, tdata}. The head entry is shown on
// Dout/Dout_last, and the pop input removes it. A two-state FSM (IDLE/FRAME)
// counts the beats in each frame. Every completed frame raises frame_done for
// one cycle and reports its length on frame_len (saturating at 255).
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   tdata/tvalid/tlast    inbound stream beat
//   tready                sink accepts this cycle (in_en & ~full, 0 in reset)
//   in_en                 acceptance enable
//   pop                   remove head entry (ignored when empty)
//   Dout/Dout_last        head entry, registered show-ahead
//   buff_count/empty/full occupancy
//   frame_done            one-cycle pulse after a tlast beat is accepted
//   frame_len             beats in the last completed frame, saturating at 255
//   frame_count           completed frames, wraps modulo 256
//   in_frame              FSM is inside a multi-beat frame
module stream_sink #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    tdata,
  input  logic          tvalid,
  output logic          tready,
  input  logic          tlast,
  input  logic          in_en,
  input  logic          pop,
  output logic [7:0]    Dout,
  output logic          Dout_last,
  output logic [CW-1:0] buff_count,
  output logic          empty,
  output logic          full,
  output logic          frame_done,
  output logic [7:0]    frame_len,
  output logic [7:0]    frame_count,
  output logic          in_frame
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_FRAME
  } state_t;

  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [8:0]    dout_q, dout_d;
  state_t        state_q, state_d;
  logic [7:0]    len_cnt_q, len_cnt_d;
  logic [7:0]    frame_len_q, frame_len_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic          frame_done_q, frame_done_d;

  logic       accept;
  logic       pop_eff;
  logic [8:0] in_word;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign tready     = rst & in_en & ~full;
  assign accept     = tvalid & tready;
  assign pop_eff    = pop & ~empty;
  assign in_word    = {tlast, tdata};

  assign buff_count  = count_q;
  assign Dout        = dout_q[7:0];
  assign Dout_last   = dout_q[8];
  assign frame_done  = frame_done_q;
  assign frame_len   = frame_len_q;
  assign frame_count = frame_count_q;
  assign in_frame    = (state_q == S_FRAME);

  // FIFO pointers, occupancy and registered head
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;

    if (accept)  wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_eff) rd_ptr_d = ptr_inc(rd_ptr_q);

    if (accept && !pop_eff)      count_d = count_q + CW'(1);
    else if (!accept && pop_eff) count_d = count_q - CW'(1);

    // Dout is a register, so it is loaded with the entry that will be the head
    // after this edge. If that entry is being written on this same edge, it is
    // not yet in mem_q, so it is forwarded from the input.
    if (count_d != '0) begin
      if (accept && (rd_ptr_d == wr_ptr_q)) dout_d = in_word;
      else                                  dout_d = mem_q[rd_ptr_d];
    end
  end

  // Frame FSM
  always_comb begin
    state_d       = state_q;
    len_cnt_d     = len_cnt_q;
    frame_len_d   = frame_len_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;

    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (tlast) begin
            frame_done_d  = 1'b1;
            frame_len_d   = 8'd1;
            frame_count_d = frame_count_q + 8'd1;
          end else begin
            state_d   = S_FRAME;
            len_cnt_d = 8'd1;
          end
        end
        S_FRAME: begin
          if (tlast) begin
            state_d       = S_IDLE;
            frame_done_d  = 1'b1;
            frame_len_d   = (len_cnt_q == 8'hFF) ? 8'hFF : len_cnt_q + 8'd1;
            frame_count_d = frame_count_q + 8'd1;
          end else if (len_cnt_q != 8'hFF) begin
            len_cnt_d = len_cnt_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Storage array: no reset needed, since entries are only read once written
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= in_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dout_q        <= '0;
      state_q       <= S_IDLE;
      len_cnt_q     <= '0;
      frame_len_q   <= '0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      dout_q        <= dout_d;
      state_q       <= state_d;
      len_cnt_q     <= len_cnt_d;
      frame_len_q   <= frame_len_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_stream_sink.sv
// Testbench for stream_sink: directed steps followed by a random phase. All
// expected values come from a queue-based reference model of the FIFO and
// framing rules.
module tb_stream_sink;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          in_en;
  logic          pop;
  logic [7:0]    Dout;
  logic          Dout_last;
  logic [CW-1:0] buff_count;
  logic          empty;
  logic          full;
  logic          frame_done;
  logic [7:0]    frame_len;
  logic [7:0]    frame_count;
  logic          in_frame;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [8:0] mq[$];
  bit         m_inframe;
  int         m_len;
  int         m_flen;
  int         m_fcnt;
  bit         m_done;

  stream_sink #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .tdata      (tdata),
    .tvalid     (tvalid),
    .tready     (tready),
    .tlast      (tlast),
    .in_en      (in_en),
    .pop        (pop),
    .Dout       (Dout),
    .Dout_last  (Dout_last),
    .buff_count (buff_count),
    .empty      (empty),
    .full       (full),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .frame_count(frame_count),
    .in_frame   (in_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_inframe = 0;
    m_len     = 0;
    m_flen    = 0;
    m_fcnt    = 0;
    m_done    = 0;
  endtask

  task automatic check_outputs();
    chk("buff_count", 32'(buff_count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    if (mq.size() > 0) begin
      chk("Dout", 32'(Dout), 32'(mq[0][7:0]));
      chk("Dout_last", 32'(Dout_last), 32'(mq[0][8]));
    end
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("frame_len", 32'(frame_len), 32'(m_flen));
    chk("frame_count", 32'(frame_count), 32'(m_fcnt));
    chk("in_frame", 32'(in_frame), 32'(m_inframe));
  endtask

  // One clock: check tready before the edge, apply the rules at the edge,
  // then check the registered outputs just after it.
  task automatic step();
    bit acc;
    bit pe;
    #1;
    acc = rst && in_en && (mq.size() < DEPTH);
    chk("tready", 32'(tready), 32'(acc));
    acc = acc && tvalid;
    pe  = pop && (mq.size() > 0);
    @(posedge clk);
    m_done = 0;
    if (pe) void'(mq.pop_front());
    if (acc) begin
      mq.push_back({tlast, tdata});
      if (tlast) begin
        m_flen    = m_inframe ? m_len + 1 : 1;
        if (m_flen > 255) m_flen = 255;
        m_fcnt    = (m_fcnt + 1) % 256;
        m_inframe = 0;
        m_done    = 1;
      end else if (m_inframe) begin
        m_len++;
      end else begin
        m_inframe = 1;
        m_len     = 1;
      end
    end
    #1;
    check_outputs();
  endtask

  // Asynchronous assert in mid-cycle; release just after a rising edge
  task automatic do_reset();
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_Dout", 32'(Dout), 32'd0);
    chk("rst_Dout_last", 32'(Dout_last), 32'd0);
    check_outputs();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0; in_en = 1'b1; pop = 1'b0;
    model_reset();
    #2;
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_Dout", 32'(Dout), 32'd0);
    chk("rst_Dout_last", 32'(Dout_last), 32'd0);
    check_outputs();
    @(posedge clk);
    #1 rst = 1'b1;

    // Three-beat frame, then drain it
    tvalid = 1'b1;
    tdata = 8'h11; tlast = 1'b0; step();
    tdata = 8'h22; step();
    tdata = 8'h33; tlast = 1'b1; step();
    chk("t1_done", 32'(frame_done), 32'd1);
    chk("t1_len", 32'(frame_len), 32'd3);
    chk("t1_cnt", 32'(frame_count), 32'd1);
    tvalid = 1'b0; tlast = 1'b0; pop = 1'b1;
    chk("t1_d0", 32'(Dout), 32'h11);
    step();
    chk("t1_d1", 32'(Dout), 32'h22);
    chk("t1_l1", 32'(Dout_last), 32'd0);
    step();
    chk("t1_d2", 32'(Dout), 32'h33);
    chk("t1_l2", 32'(Dout_last), 32'd1);
    step();
    chk("t1_empty", 32'(empty), 32'd1);
    pop = 1'b0;

    // Fill to DEPTH; the 17th beat is held off until a pop makes room
    tvalid = 1'b1; tlast = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      tdata = 8'($urandom);
      step();
    end
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count", 32'(buff_count), 32'd16);
    tdata = 8'hA5;
    step();
    chk("t2_held", 32'(buff_count), 32'd16);
    pop = 1'b1; step(); pop = 1'b0;
    chk("t2_tready", 32'(tready), 32'd1);
    step();
    chk("t2_refill", 32'(buff_count), 32'd16);
    tvalid = 1'b0; pop = 1'b1;
    repeat (11) step();
    chk("t3_five", 32'(buff_count), 32'd5);

    // Simultaneous accept and pop keep the count at 5
    tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tdata = 8'($urandom);
      step();
      chk("t3_hold", 32'(buff_count), 32'd5);
    end
    tvalid = 1'b0;
    repeat (7) step();
    chk("t3_emptypop", 32'(buff_count), 32'd0);
    pop = 1'b0; tvalid = 1'b1; tdata = 8'h5C; step();
    tvalid = 1'b0;
    chk("t3_after", 32'(Dout), 32'h5C);
    pop = 1'b1; step(); pop = 1'b0;

    // 257 single-beat frames with continuous popping
    do_reset();
    tvalid = 1'b1; tlast = 1'b1; pop = 1'b1;
    for (int i = 0; i < 257; i++) begin
      tdata = 8'($urandom);
      step();
      chk("t4_len", 32'(frame_len), 32'd1);
      chk("t4_idle", 32'(in_frame), 32'd0);
    end
    chk("t4_wrap", 32'(frame_count), 32'd1);
    tvalid = 1'b0; tlast = 1'b0;
    step(); pop = 1'b0;

    // Reset in mid-frame
    tvalid = 1'b1;
    tdata = 8'h01; step();
    tdata = 8'h02; step();
    tvalid = 1'b0;
    chk("t5_inframe", 32'(in_frame), 32'd1);
    do_reset();
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_idle", 32'(in_frame), 32'd0);
    tvalid = 1'b1; tdata = 8'h03; step();
    tlast = 1'b1; tdata = 8'h04; step();
    chk("t5_len", 32'(frame_len), 32'd2);
    tvalid = 1'b0; tlast = 1'b0;

    // 300-beat frame popped as it streams, with an in_en gap of 10 cycles
    pop = 1'b1; tvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        in_en = 1'b0;
        repeat (10) begin
          step();
          chk("t6_tready", 32'(tready), 32'd0);
          chk("t6_inframe", 32'(in_frame), 32'd1);
        end
        in_en = 1'b1;
      end
      tdata = 8'($urandom);
      tlast = (i == 299);
      step();
    end
    chk("t6_len", 32'(frame_len), 32'd255);
    tvalid = 1'b0; tlast = 1'b0;
    repeat (2) step();
    pop = 1'b0;

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      tvalid = ($urandom_range(0, 3) != 0);
      tlast  = ($urandom_range(0, 3) == 0);
      in_en  = ($urandom_range(0, 7) != 0);
      pop    = (i < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      tdata  = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
